// File: rtl/sram_bist_if.sv
// sram_bist_if: signal bundle between the SRAM BIST engine, its system controller
// and the board-level SRAM pins.
//   Control : start, mode (to engine); busy, done, pass, err_cnt, first_err_addr (from engine)
//   SRAM    : sram_addr, sram_dq_o, sram_dq_oe, strobes (from engine); sram_dq_i (from pad)
// master modport = BIST engine side, slave modport = controller/SRAM side.
interface sram_bist_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ERR_W  = 16
);
    logic              start;
    logic [1:0]        mode;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_i;
    logic              sram_ce_n;
    logic              sram_we_n;
    logic              sram_oe_n;

    modport master (
        input  start, mode, sram_dq_i,
        output busy, done, pass, err_cnt, first_err_addr,
               sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n
    );

    modport slave (
        output start, mode, sram_dq_i,
        input  busy, done, pass, err_cnt, first_err_addr,
               sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_bist.sv
// sram_bist: built-in self-test engine for an external asynchronous SRAM.
// On start it writes a selected pattern over addresses 0..LAST_ADDR, reads every word
// back, compares, and reports pass/fail, a saturating error count and the first failing
// address.
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : sram_bist_if master modport (control/status and SRAM pins)
// All outputs are registered.
module sram_bist #(
    parameter int unsigned       ADDR_W    = 18,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       LAST_ADDR = 2**18 - 1,
    parameter int unsigned       WAIT_CYC  = 2,
    parameter int unsigned       ERR_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_POLY = 16'hB400,
    parameter logic [DATA_W-1:0] LFSR_SEED = 16'h0001
) (
    input logic         sys_clk,
    input logic         sys_rst_n,
    sram_bist_if.master bus
);
    localparam int unsigned       CNT_W     = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WAIT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {
        StIdle, StWrSetup, StWrPulse, StWrHold, StRdPulse, StRdCmp, StDone
    } state_e;

    state_e            state;
    logic [1:0]        mode_r;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] lfsr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] dq_o;
    logic              dq_oe, ce_n, we_n, oe_n;
    logic              busy, done, pass;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic              mismatch;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] l);
        logic [ADDR_W+DATA_W-1:0] ext;
        // Zero-extend so narrow address buses still fill the data word.
        ext = {{DATA_W{1'b0}}, a};
        case (m)
            2'd0:    pattern = ext[DATA_W-1:0];
            2'd1:    pattern = ~ext[DATA_W-1:0];
            2'd2:    pattern = a[0] ? {DATA_W/2{2'b10}} : {DATA_W/2{2'b01}};
            default: pattern = l;
        endcase
    endfunction

    // Right-shifting Galois LFSR.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] l);
        lfsr_next = l[0] ? ((l >> 1) ^ LFSR_POLY) : (l >> 1);
    endfunction

    assign mismatch = (rd_data != pattern(mode_r, addr, lfsr));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= StIdle;
            mode_r         <= 2'd0;
            cnt            <= '0;
            addr           <= '0;
            lfsr           <= LFSR_SEED;
            rd_data        <= '0;
            dq_o           <= '0;
            dq_oe          <= 1'b0;
            ce_n           <= 1'b1;
            we_n           <= 1'b1;
            oe_n           <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state          <= StWrSetup;
                        mode_r         <= bus.mode;
                        addr           <= '0;
                        lfsr           <= LFSR_SEED;
                        // Uses the incoming mode: mode_r is not yet updated.
                        dq_o           <= pattern(bus.mode, '0, LFSR_SEED);
                        dq_oe          <= 1'b1;
                        ce_n           <= 1'b0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                    end
                end
                StWrSetup: begin
                    state <= StWrPulse;
                    we_n  <= 1'b0;
                    cnt   <= '0;
                end
                StWrPulse: begin
                    if (cnt == CNT_LAST) begin
                        state <= StWrHold;
                        we_n  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StWrHold: begin
                    if (addr == ADDR_LAST) begin
                        state <= StRdPulse;
                        addr  <= '0;
                        lfsr  <= LFSR_SEED;
                        dq_oe <= 1'b0;
                        oe_n  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        state <= StWrSetup;
                        addr  <= addr + 1'b1;
                        lfsr  <= lfsr_next(lfsr);
                        dq_o  <= pattern(mode_r, addr + 1'b1, lfsr_next(lfsr));
                    end
                end
                StRdPulse: begin
                    if (cnt == CNT_LAST) begin
                        state   <= StRdCmp;
                        rd_data <= bus.sram_dq_i;
                        ce_n    <= 1'b1;
                        oe_n    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StRdCmp: begin
                    if (mismatch) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) first_err_addr <= addr;
                    end
                    if (addr == ADDR_LAST) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Includes this final word's result.
                        pass  <= (err_cnt == '0) && !mismatch;
                    end else begin
                        state <= StRdPulse;
                        addr  <= addr + 1'b1;
                        lfsr  <= lfsr_next(lfsr);
                        ce_n  <= 1'b0;
                        oe_n  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.err_cnt        = err_cnt;
    assign bus.first_err_addr = first_err_addr;
    assign bus.sram_addr      = addr;
    assign bus.sram_dq_o      = dq_o;
    assign bus.sram_dq_oe     = dq_oe;
    assign bus.sram_ce_n      = ce_n;
    assign bus.sram_we_n      = we_n;
    assign bus.sram_oe_n      = oe_n;
endmodule

// File: tb/tb_sram_bist.sv
// tb_sram_bist: directed self-checking bench for sram_bist with a 16-word SRAM model.
// dut0 (ERR_W=16) talks to a fault-injectable model; dut1 (ERR_W=3) sees a data bus
// stuck at zero.
module tb_sram_bist;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;
    int   fault = 0;  // 0 ideal, 1 bit3 stuck-1 at addr 5, 2 addr line 0 stuck-0
    int   cyc;
    int   base;

    always #5 clk = ~clk;

    sram_bist_if #(.ADDR_W(18), .DATA_W(16), .ERR_W(16)) bus0 ();
    sram_bist_if #(.ADDR_W(18), .DATA_W(16), .ERR_W(3))  bus1 ();

    sram_bist #(.LAST_ADDR(15), .WAIT_CYC(2), .ERR_W(16)) dut0 (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus0)
    );

    sram_bist #(.LAST_ADDR(15), .WAIT_CYC(2), .ERR_W(3)) dut1 (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus1)
    );

    // SRAM model
    logic [15:0] mem [16];
    logic [3:0]  wa;
    assign wa = (fault == 2) ? {bus0.sram_addr[3:1], 1'b0} : bus0.sram_addr[3:0];
    always @(posedge clk)
        if (!bus0.sram_ce_n && !bus0.sram_we_n && bus0.sram_dq_oe) mem[wa] <= bus0.sram_dq_o;
    assign bus0.sram_dq_i = (fault == 1 && wa == 4'd5) ? (mem[wa] | 16'h0008) : mem[wa];
    assign bus1.sram_dq_i = 16'h0000;

    // Write-strobe monitor on dut0
    int          we_run = 0;
    int          we_pulses = 0;
    int          we_min = 1000;
    int          we_max = 0;
    int          viol = 0;
    logic        prev_we_low = 1'b0;
    logic [17:0] prev_addr = '0;
    logic [15:0] prev_dq = '0;
    logic [15:0] wlog[$];

    always @(negedge clk) begin
        if (!bus0.sram_we_n) begin
            if (!prev_we_low) wlog.push_back(bus0.sram_dq_o);
            we_run <= we_run + 1;
        end else if (prev_we_low) begin
            we_pulses <= we_pulses + 1;
            if (we_run < we_min) we_min <= we_run;
            if (we_run > we_max) we_max <= we_run;
            we_run <= 0;
        end
        if ((!bus0.sram_we_n || prev_we_low) &&
            (bus0.sram_addr != prev_addr || bus0.sram_dq_o != prev_dq || bus0.sram_ce_n))
            viol <= viol + 1;
        prev_we_low <= !bus0.sram_we_n;
        prev_addr   <= bus0.sram_addr;
        prev_dq     <= bus0.sram_dq_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on dut0, count busy clocks; optional extra start at busy clock poke.
    task automatic run0(input logic [1:0] m, input int poke, output int n);
        @(negedge clk);
        bus0.start = 1'b1;
        bus0.mode  = m;
        @(negedge clk);
        bus0.start = 1'b0;
        n = 0;
        while (bus0.busy && n < 2000) begin
            if (n == poke) bus0.start = 1'b1;
            @(negedge clk);
            bus0.start = 1'b0;
            n++;
        end
    endtask

    initial begin
        bus0.start = 1'b0;
        bus0.mode  = 2'd0;
        bus1.start = 1'b0;
        bus1.mode  = 2'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_pass", bus0.pass, 0);
        check("rst_err", bus0.err_cnt, 0);
        check("rst_first", bus0.first_err_addr, 0);
        check("rst_addr", bus0.sram_addr, 0);
        check("rst_dq_o", bus0.sram_dq_o, 0);
        check("rst_dq_oe", bus0.sram_dq_oe, 0);
        check("rst_strobes", {bus0.sram_ce_n, bus0.sram_we_n, bus0.sram_oe_n}, 3'b111);
        rst_n = 1'b1;

        // Ideal, mode 0
        base = wlog.size();
        run0(2'd0, -1, cyc);
        check("t1_cycles", cyc, 112);
        check("t1_done", bus0.done, 1);
        check("t1_pass", bus0.pass, 1);
        check("t1_err", bus0.err_cnt, 0);
        check("t1_strobes", {bus0.sram_ce_n, bus0.sram_we_n, bus0.sram_oe_n}, 3'b111);
        check("t1_dq_oe", bus0.sram_dq_oe, 0);
        check("t1_we_pulses", we_pulses, 16);
        check("t1_we_min", we_min, 2);
        check("t1_we_max", we_max, 2);
        check("t1_stable", viol, 0);
        check("t1_wdata1", wlog[base+1], 16'h0001);
        check("t1_wdata15", wlog[base+15], 16'h000F);

        // Bit 3 stuck-at-1 at address 5
        fault = 1;
        run0(2'd0, -1, cyc);
        check("t2_err", bus0.err_cnt, 1);
        check("t2_first", bus0.first_err_addr, 5);
        check("t2_pass", bus0.pass, 0);
        check("t2_done", bus0.done, 1);

        // Address line 0 stuck-at-0, checkerboard
        fault = 2;
        run0(2'd2, -1, cyc);
        check("t3_err", bus0.err_cnt, 8);
        check("t3_first", bus0.first_err_addr, 0);
        check("t3_pass", bus0.pass, 0);

        // LFSR, two consecutive runs
        fault = 0;
        for (int r = 0; r < 2; r++) begin
            base = wlog.size();
            run0(2'd3, -1, cyc);
            check("t4_pass", bus0.pass, 1);
            check("t4_err", bus0.err_cnt, 0);
            check("t4_w0", wlog[base+0], 16'h0001);
            check("t4_w1", wlog[base+1], 16'hB400);
            check("t4_w2", wlog[base+2], 16'h5A00);
        end

        // ERR_W=3, data bus stuck at 0, mode 1
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.mode  = 2'd1;
        @(negedge clk);
        bus1.start = 1'b0;
        cyc = 0;
        while (bus1.busy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_cycles", cyc, 112);
        check("t5_err_sat", bus1.err_cnt, 7);
        check("t5_first", bus1.first_err_addr, 0);
        check("t5_pass", bus1.pass, 0);
        check("t5_done", bus1.done, 1);

        // Start while busy is ignored
        run0(2'd0, 20, cyc);
        check("t6_cycles", cyc, 112);
        check("t6_pass", bus0.pass, 1);

        // Reset mid-test is immediate
        @(negedge clk);
        bus0.start = 1'b1;
        bus0.mode  = 2'd0;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (30) @(negedge clk);
        check("t7_busy_before", bus0.busy, 1);
        rst_n = 1'b0;
        #1;
        check("t7_strobes", {bus0.sram_ce_n, bus0.sram_we_n, bus0.sram_oe_n}, 3'b111);
        check("t7_dq_oe", bus0.sram_dq_oe, 0);
        check("t7_busy", bus0.busy, 0);
        check("t7_done", bus0.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run0(2'd0, -1, cyc);
        check("t7_cycles", cyc, 112);
        check("t7_pass", bus0.pass, 1);
        check("t7_done_after", bus0.done, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
